// File: rtl/dmr_commit_if.sv
// Commit and error signals shared between the lockstep core pair and the checker.
interface dmr_commit_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  a_valid_i;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic [DATA_WIDTH-1:0] a_data_i;
  logic                  b_valid_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [DATA_WIDTH-1:0] b_data_i;
  logic                  recovery_i;
  logic                  error_o;
  logic [ADDR_WIDTH-1:0] error_addr_o;
  logic [1:0]            error_cause_o;
  logic [7:0]            error_count_o;

  modport master (
    output a_valid_i, a_addr_i, a_data_i,
    output b_valid_i, b_addr_i, b_data_i,
    output recovery_i,
    input  error_o, error_addr_o, error_cause_o, error_count_o
  );

  modport slave (
    input  a_valid_i, a_addr_i, a_data_i,
    input  b_valid_i, b_addr_i, b_data_i,
    input  recovery_i,
    output error_o, error_addr_o, error_cause_o, error_count_o
  );
endinterface

// File: rtl/dmr_commit_checker.sv
// Lockstep commit checker: buffers each core's writebacks, compares FIFO heads
// in order and pulses an error on mismatch, commit-skew timeout or overflow.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_CHECK    | normal operation: push, compare, detect errors
// S_WAIT_REC | error raised; FIFOs frozen until the controller starts replay
// S_RECOVER  | replay in progress; FIFOs flushed, skew timer reloaded
module dmr_commit_checker #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input logic         clk,
  input logic         rst,
  dmr_commit_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int SW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_CHECK, S_WAIT_REC, S_RECOVER} state_t;

  state_t state, state_n;

  logic [EW-1:0] mem_a [DEPTH];
  logic [EW-1:0] mem_b [DEPTH];
  logic [PW:0]   wr_a, rd_a, wr_b, rd_b;
  logic [SW-1:0] skew_left, skew_n;

  logic                  err_q;
  logic [ADDR_WIDTH-1:0] err_addr_q;
  logic [1:0]            err_cause_q;
  logic [7:0]            err_count_q;

  logic empty_a, empty_b, full_a, full_b;
  logic [EW-1:0] head_a, head_b;
  logic push_a, push_b, pop, flush, ovf_a, ovf_b;
  logic fire;
  logic [ADDR_WIDTH-1:0] fire_addr;
  logic [1:0] fire_cause;

  assign empty_a = (wr_a == rd_a);
  assign empty_b = (wr_b == rd_b);
  assign full_a  = (wr_a[PW] != rd_a[PW]) && (wr_a[PW-1:0] == rd_a[PW-1:0]);
  assign full_b  = (wr_b[PW] != rd_b[PW]) && (wr_b[PW-1:0] == rd_b[PW-1:0]);
  assign head_a  = mem_a[rd_a[PW-1:0]];
  assign head_b  = mem_b[rd_b[PW-1:0]];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_CHECK;
    else     state <= state_n;
  end

  // Next state, FIFO control, skew timer and error selection
  always_comb begin
    state_n    = state;
    push_a     = 1'b0;
    push_b     = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    ovf_a      = 1'b0;
    ovf_b      = 1'b0;
    skew_n     = skew_left;
    fire       = 1'b0;
    fire_addr  = '0;
    fire_cause = 2'd0;
    case (state)
      S_CHECK: begin
        pop    = !empty_a && !empty_b;
        ovf_a  = bus.a_valid_i && full_a && !pop;
        ovf_b  = bus.b_valid_i && full_b && !pop;
        push_a = bus.a_valid_i && !ovf_a;
        push_b = bus.b_valid_i && !ovf_b;
        // Reaching here without pop and not both empty means exactly one is occupied.
        if (pop || (empty_a && empty_b)) skew_n = SW'(TIMEOUT);
        else if (skew_left != '0)        skew_n = skew_left - 1'b1;
        if (ovf_a || ovf_b) begin
          fire       = 1'b1;
          fire_cause = 2'd3;
          fire_addr  = ovf_a ? bus.a_addr_i : bus.b_addr_i;
        end else if (pop && (head_a != head_b)) begin
          fire       = 1'b1;
          fire_cause = 2'd1;
          fire_addr  = head_a[EW-1 -: ADDR_WIDTH];
        end else if (!pop && !(empty_a && empty_b) && (skew_left == SW'(1))) begin
          fire       = 1'b1;
          fire_cause = 2'd2;
          fire_addr  = empty_a ? head_b[EW-1 -: ADDR_WIDTH] : head_a[EW-1 -: ADDR_WIDTH];
        end
        // A replay already underway supersedes anything detected this cycle.
        if (bus.recovery_i) begin
          fire    = 1'b0;
          state_n = S_RECOVER;
        end else if (fire) begin
          state_n = S_WAIT_REC;
        end
      end
      S_WAIT_REC: begin
        if (bus.recovery_i) state_n = S_RECOVER;
      end
      S_RECOVER: begin
        flush  = 1'b1;
        skew_n = SW'(TIMEOUT);
        if (!bus.recovery_i) state_n = S_CHECK;
      end
      default: state_n = S_CHECK;
    endcase
  end

  // FIFO pointers and skew timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_a      <= '0;
      rd_a      <= '0;
      wr_b      <= '0;
      rd_b      <= '0;
      skew_left <= SW'(TIMEOUT);
    end else begin
      skew_left <= skew_n;
      if (flush) begin
        wr_a <= '0;
        rd_a <= '0;
        wr_b <= '0;
        rd_b <= '0;
      end else begin
        if (push_a) wr_a <= wr_a + 1'b1;
        if (push_b) wr_b <= wr_b + 1'b1;
        if (pop) begin
          rd_a <= rd_a + 1'b1;
          rd_b <= rd_b + 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents only matter between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_a) mem_a[wr_a[PW-1:0]] <= {bus.a_addr_i, bus.a_data_i};
    if (push_b) mem_b[wr_b[PW-1:0]] <= {bus.b_addr_i, bus.b_data_i};
  end

  // Registered error pulse, sticky address/cause and saturating error count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_cause_q <= 2'd0;
      err_count_q <= 8'd0;
    end else begin
      err_q <= fire;
      if (fire) begin
        err_addr_q  <= fire_addr;
        err_cause_q <= fire_cause;
        if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign bus.error_o       = err_q;
  assign bus.error_addr_o  = err_addr_q;
  assign bus.error_cause_o = err_cause_q;
  assign bus.error_count_o = err_count_q;
endmodule

// File: doc/dmr_commit_checker.md
# dmr_commit_checker

Lockstep checker for the dual-modular-redundant core pair. It sits directly upstream of the replay controller and drives that controller's error input. Each core's register-writeback commits are buffered in a small per-core FIFO, and the FIFO heads are compared in order. A mismatch, a commit-skew timeout or a FIFO overflow raises a one-cycle error pulse that carries the offending register address. The checker stays quiet while the controller holds fetch blocked for register replay.

## Interface
Parameters:
- ADDR_WIDTH, 5: register address width; matches the replay controller.
- DATA_WIDTH, 32: writeback data width.
- DEPTH, 4: entries per commit FIFO; power of two, at least 2.
- TIMEOUT, 16: maximum cycles one FIFO may be non-empty while the other is empty; at least 2.

Ports (clock and reset: one clock; reset is asynchronous and active-high):
- clk  in  1  clock for all state.
- rst  in  1  asynchronous active-high reset.
- a_valid_i  in  1  core A commits a writeback this cycle.
- a_addr_i  in  ADDR_WIDTH  core A destination register.
- a_data_i  in  DATA_WIDTH  core A writeback data.
- b_valid_i, b_addr_i, b_data_i  in  1 / ADDR_WIDTH / DATA_WIDTH  same signals for core B.
- recovery_i  in  1  replay in progress; driven from the controller's fetch-block output.
- error_o  out  1  one-cycle error pulse to the controller.
- error_addr_o  out  ADDR_WIDTH  register address of the last error; held until the next error.
- error_cause_o  out  2  cause of the last error: 0 none, 1 mismatch, 2 timeout, 3 overflow.
- error_count_o  out  8  saturating count of errors raised.

## Operation
- Each FIFO stores {addr, data} pairs.
- A push happens when valid_i is high and the FSM is in CHECK.
- Push and pop may occur in the same cycle. A push into a full FIFO with a simultaneous pop is legal.
- Overflow condition: a push into a full FIFO with no pop in that cycle. The entry is dropped and an overflow error is raised.
- Compare condition: both FIFOs non-empty in CHECK.
  - Both heads are popped together.
  - Match requires equal addr and equal data. Anything else is a mismatch; error_addr_o takes A's head addr.
- Skew counter:
  - Increments each cycle exactly one FIFO is non-empty.
  - Clears when both FIFOs are empty, on any pop, and in RECOVER.
  - Reaching TIMEOUT raises a timeout error; error_addr_o takes the non-empty FIFO's head addr.
- Error priority within one cycle: overflow, then mismatch, then timeout. Only one error is raised per cycle.
- FSM states:
  - CHECK: normal operation. An error moves to WAIT_REC. recovery_i high with no error moves to RECOVER.
  - WAIT_REC: pushes, compares and error detection are disabled; FIFO contents are frozen. recovery_i high moves to RECOVER.
  - RECOVER: both FIFOs are flushed every cycle and the skew counter is cleared. recovery_i low moves to CHECK.
- recovery_i high in CHECK in the same cycle as an error condition: recovery wins. No error is raised and the FSM goes to RECOVER.
- error_count_o increments on every error_o pulse and saturates at 255.
- Reset values:
  - FSM state CHECK; both FIFOs empty; skew counter 0.
  - error_o 0, error_addr_o 0, error_cause_o 0, error_count_o 0.
  - Reset asserted mid-operation returns all of the above within the same cycle.

## Timing
- All outputs are registered.
- A commit pushed at edge N is visible at the FIFO head in cycle N+1.
- If both heads are present in cycle N+1, the compare result sets error_o at edge N+2. Minimum latency from commit to error_o is therefore 2 cycles.
- error_o is high for exactly one cycle. error_addr_o and error_cause_o update on the same edge that raises error_o.
- The transition to WAIT_REC takes effect on the same edge that raises error_o. Commits in the following cycles are ignored.
- Timeout fires on the edge at which the skew count reaches TIMEOUT: with default parameters, 16 cycles after the lone entry becomes visible.
- A flush in RECOVER takes effect on each edge while recovery_i is high. Commits presented in the cycle recovery_i falls are still ignored; pushes resume on the following cycle.

## Test plan
- Matching stream: A and B commit (3, 0xDEADBEEF) in the same cycle, 20 times. Required: error_o never rises, error_count_o = 0, both FIFOs empty afterwards.
- Skewed match: B lags A by 3 cycles on 10 commits with DEPTH=4. Required: no error, and no overflow or timeout.
- Data mismatch: A commits (7, 0x1), B commits (7, 0x2) at edge N. Required: error_o high only in cycle N+2, error_addr_o = 7, error_cause_o = 1, error_count_o = 1; commits in the next cycles are ignored.
- Timeout: only A commits (9, 0x5). Required: one error_o pulse 16 cycles after the head is visible, with error_cause_o = 2 and error_addr_o = 9.
- Overflow: A commits 5 times while B is idle, DEPTH=4. Required: error on the 5th push with error_cause_o = 3.
- Recovery handshake: after an error, raise recovery_i for 32 cycles, then drop it. Required:
  - FSM in WAIT_REC while recovery_i is low, then RECOVER, then back to CHECK.
  - FIFOs empty after recovery.
  - Matching commits two cycles after the fall pass without error.
  - Asserting rst mid-RECOVER clears every output to 0.
